axi_mesh_responder: RTL and testbench

- AXI4 slave endpoint terminating one `m_axi_o` port of the XY mesh: accepts the AW/W and AR requests the mesh bridge issues and returns B/R responses.
- Backed by an internal word-addressed memory; used as a per-node target in mesh tests and as a simple on-node scratchpad.
- Independent write and read engines; one outstanding transaction per direction; INCR bursts only.

---
 rtl/axi_mesh_responder.sv | 190 +++++++++++++++++++
 tb/tb_axi_mesh_responder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mesh_responder.sv
// AXI4 slave endpoint for one mesh m_axi_o port: word memory behind
// independent single-outstanding write and read engines (INCR only).
module axi_mesh_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_W_WIDTH = 4,
    parameter int ID_R_WIDTH = 4,
    parameter int MEM_WORDS  = 256
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic [ID_W_WIDTH-1:0]   AWID,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [7:0]              AWLEN,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WLAST,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [ID_W_WIDTH-1:0]   BID,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [ID_R_WIDTH-1:0]   ARID,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic [7:0]              ARLEN,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [ID_R_WIDTH-1:0]   RID,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RLAST,
    output logic                    RVALID,
    input  logic                    RREADY
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LSB   = $clog2(BYTES);
    localparam int IDXW  = $clog2(MEM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] STEP  = ADDR_WIDTH'(BYTES);
    localparam logic [ADDR_WIDTH-1:0] DEPTH = ADDR_WIDTH'(MEM_WORDS);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    w_state_t              w_state, w_next;
    logic [ID_W_WIDTH-1:0] w_id;
    logic [ADDR_WIDTH-1:0] w_addr, w_idx;
    logic [7:0]            w_len, w_cnt;
    logic                  w_err, w_ok, w_last_beat;
    logic                  awready_q, wready_q, bvalid_q;
    logic                  aw_hs, w_hs, b_hs;

    assign aw_hs       = AWVALID && awready_q;
    assign w_hs        = WVALID && wready_q;
    assign b_hs        = bvalid_q && BREADY;
    assign w_last_beat = (w_cnt == w_len);
    assign w_idx       = w_addr >> LSB;
    assign w_ok        = (w_idx < DEPTH);

    always_comb begin
        w_next = w_state;
        unique case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_hs && w_last_beat) w_next = W_RESP;
            W_RESP:  if (b_hs) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state   <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            w_id      <= '0;
            w_addr    <= '0;
            w_len     <= '0;
            w_cnt     <= '0;
            w_err     <= 1'b0;
        end else begin
            w_state   <= w_next;
            awready_q <= (w_next == W_IDLE);
            wready_q  <= (w_next == W_DATA);
            bvalid_q  <= (w_next == W_RESP);
            if (aw_hs) begin
                w_id   <= AWID;
                w_addr <= AWADDR;
                w_len  <= AWLEN;
                w_cnt  <= '0;
                w_err  <= 1'b0;
            end else if (w_hs) begin
                w_addr <= w_addr + STEP;
                w_cnt  <= w_cnt + 8'd1;
                // burst length comes from AWLEN; a WLAST disagreement only flags
                if (!w_ok || (WLAST != w_last_beat))
                    w_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (w_hs && w_ok) begin
            for (int b = 0; b < BYTES; b++) begin
                if (WSTRB[b])
                    mem[w_idx[IDXW-1:0]][b*8 +: 8] <= WDATA[b*8 +: 8];
            end
        end
    end

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BID     = w_id;
    assign BRESP   = {w_err & bvalid_q, 1'b0};

    r_state_t              r_state, r_next;
    logic [ID_R_WIDTH-1:0] r_id;
    logic [ADDR_WIDTH-1:0] r_addr, f_addr, f_idx;
    logic [7:0]            r_len, r_cnt;
    logic                  f_ok;
    logic [DATA_WIDTH-1:0] f_data;
    logic                  arready_q, rvalid_q, rlast_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;
    logic                  ar_hs, r_hs;

    assign ar_hs  = ARVALID && arready_q;
    assign r_hs   = rvalid_q && RREADY;
    // r_addr always points at the beat to present next
    assign f_addr = ar_hs ? ARADDR : r_addr;
    assign f_idx  = f_addr >> LSB;
    assign f_ok   = (f_idx < DEPTH);
    assign f_data = f_ok ? mem[f_idx[IDXW-1:0]] : '0;

    always_comb begin
        r_next = r_state;
        unique case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_DATA;
            R_DATA:  if (r_hs && rlast_q) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state   <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            r_id      <= '0;
            r_addr    <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
            rlast_q   <= 1'b0;
        end else begin
            r_state   <= r_next;
            arready_q <= (r_next == R_IDLE);
            rvalid_q  <= (r_next == R_DATA);
            if (ar_hs) begin
                r_id    <= ARID;
                r_len   <= ARLEN;
                r_cnt   <= '0;
                r_addr  <= ARADDR + STEP;
                rdata_q <= f_data;
                rresp_q <= f_ok ? 2'b00 : 2'b10;
                rlast_q <= (ARLEN == 8'd0);
            end else if (r_hs && !rlast_q) begin
                r_cnt   <= r_cnt + 8'd1;
                r_addr  <= r_addr + STEP;
                rdata_q <= f_data;
                rresp_q <= f_ok ? 2'b00 : 2'b10;
                rlast_q <= ((r_cnt + 8'd1) == r_len);
            end
        end
    end

    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RID     = r_id;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;
    assign RLAST   = rlast_q;

endmodule

// File: tb/tb_axi_mesh_responder.sv
// Directed bench for axi_mesh_responder: writes, bursts, stalls,
// out-of-range beats, WLAST mismatch, concurrency and mid-burst reset.
module tb_axi_mesh_responder;
    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [3:0]  AWID;
    logic [15:0] AWADDR;
    logic [7:0]  AWLEN;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic [3:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [3:0]  ARID;
    logic [15:0] ARADDR;
    logic [7:0]  ARLEN;
    logic        ARVALID;
    logic        ARREADY;
    logic [3:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    axi_mesh_responder #(
        .DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_W_WIDTH(4),
        .ID_R_WIDTH(4), .MEM_WORDS(256)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
        .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic aw(input logic [3:0] id, input logic [15:0] addr,
                      input logic [7:0] len);
        int n = 0;
        AWID = id; AWADDR = addr; AWLEN = len; AWVALID = 1'b1;
        while (!AWREADY && n < 50) begin @(negedge ACLK); n++; end
        chk("aw_wait", AWREADY, 1);
        @(negedge ACLK);
        AWVALID = 1'b0;
    endtask

    task automatic wbeat(input logic [31:0] d, input logic [3:0] s,
                         input logic last);
        int n = 0;
        WDATA = d; WSTRB = s; WLAST = last; WVALID = 1'b1;
        while (!WREADY && n < 50) begin @(negedge ACLK); n++; end
        chk("w_wait", WREADY, 1);
        @(negedge ACLK);
        WVALID = 1'b0; WLAST = 1'b0;
    endtask

    task automatic bresp(input logic [3:0] id, input logic [1:0] resp);
        int n = 0;
        BREADY = 1'b0;
        while (!BVALID && n < 50) begin @(negedge ACLK); n++; end
        chk("b_wait", BVALID, 1);
        chk("bid", BID, id);
        chk("bresp", BRESP, resp);
        @(negedge ACLK);
        chk("b_hold_valid", BVALID, 1);
        chk("b_hold_resp", BRESP, resp);
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
        chk("b_drop", BVALID, 0);
        chk("awready_after_b", AWREADY, 1);
    endtask

    task automatic ar(input logic [3:0] id, input logic [15:0] addr,
                      input logic [7:0] len);
        int n = 0;
        ARID = id; ARADDR = addr; ARLEN = len; ARVALID = 1'b1;
        while (!ARREADY && n < 50) begin @(negedge ACLK); n++; end
        chk("ar_wait", ARREADY, 1);
        @(negedge ACLK);
        ARVALID = 1'b0;
        chk("rvalid_latency", RVALID, 1);
    endtask

    task automatic rbeat(input logic [3:0] id, input logic [31:0] d,
                         input logic [1:0] resp, input logic last);
        int n = 0;
        RREADY = 1'b1;
        while (!RVALID && n < 50) begin @(negedge ACLK); n++; end
        chk("r_wait", RVALID, 1);
        chk("rid", RID, id);
        chk("rdata", RDATA, d);
        chk("rresp", RRESP, resp);
        chk("rlast", RLAST, last);
        @(negedge ACLK);
    endtask

    initial begin
        int t0, hs, k;
        ARESETn = 1'b0;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0;
        BREADY = 1'b0;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARVALID = 1'b0;
        RREADY = 1'b0;

        repeat (3) @(negedge ACLK);
        chk("rst_awready", AWREADY, 0);
        chk("rst_arready", ARREADY, 0);
        chk("rst_wready", WREADY, 0);
        chk("rst_bvalid", BVALID, 0);
        chk("rst_rvalid", RVALID, 0);
        chk("rst_rdata", RDATA, 0);
        ARESETn = 1'b1;
        @(negedge ACLK);
        chk("rel_awready", AWREADY, 1);
        chk("rel_arready", ARREADY, 1);

        // single write / read
        aw(4'h3, 16'h0010, 8'd0);
        wbeat(32'hDEADBEEF, 4'hF, 1'b1);
        bresp(4'h3, 2'b00);
        ar(4'h5, 16'h0010, 8'd0);
        rbeat(4'h5, 32'hDEADBEEF, 2'b00, 1'b1);
        RREADY = 1'b0;
        chk("single_rvalid_end", RVALID, 0);

        // 4-beat burst with partial strobe on beat 1
        aw(4'h1, 16'h0024, 8'd0);
        wbeat(32'hAAAAAAAA, 4'hF, 1'b1);
        bresp(4'h1, 2'b00);
        aw(4'h2, 16'h0020, 8'd3);
        wbeat(32'h1, 4'hF, 1'b0);
        wbeat(32'h2, 4'h3, 1'b0);
        wbeat(32'h3, 4'hF, 1'b0);
        wbeat(32'h4, 4'hF, 1'b1);
        bresp(4'h2, 2'b00);
        ar(4'h6, 16'h0020, 8'd3);
        t0 = cyc;
        rbeat(4'h6, 32'h1, 2'b00, 1'b0);
        rbeat(4'h6, 32'hAAAA0002, 2'b00, 1'b0);
        rbeat(4'h6, 32'h3, 2'b00, 1'b0);
        rbeat(4'h6, 32'h4, 2'b00, 1'b1);
        RREADY = 1'b0;
        chk("stream_cycles", 64'(cyc - t0), 4);
        chk("burst_rvalid_end", RVALID, 0);

        // 8-beat read with RREADY stalls
        aw(4'h7, 16'h0040, 8'd7);
        for (int i = 0; i < 8; i++)
            wbeat(32'h100 + 32'(i), 4'hF, i == 7);
        bresp(4'h7, 2'b00);
        ar(4'h9, 16'h0040, 8'd7);
        hs = 0; k = 0;
        while (hs < 8 && k < 100) begin
            RREADY = (k % 3 == 0);
            if (RVALID) begin
                chk("stall_rdata", RDATA, 32'h100 + 32'(hs));
                chk("stall_rid", RID, 4'h9);
                chk("stall_rlast", RLAST, hs == 7);
                if (RREADY) hs++;
            end
            @(negedge ACLK);
            k++;
        end
        RREADY = 1'b0;
        chk("stall_handshakes", 64'(hs), 8);
        chk("stall_rvalid_end", RVALID, 0);

        // out-of-range second beat
        aw(4'h0, 16'h0000, 8'd0);
        wbeat(32'h5A5A5A5A, 4'hF, 1'b1);
        bresp(4'h0, 2'b00);
        aw(4'hA, 16'h03FC, 8'd1);
        wbeat(32'h11111111, 4'hF, 1'b0);
        wbeat(32'h22222222, 4'hF, 1'b1);
        bresp(4'hA, 2'b10);
        ar(4'hB, 16'h03FC, 8'd1);
        rbeat(4'hB, 32'h11111111, 2'b00, 1'b0);
        rbeat(4'hB, 32'h0, 2'b10, 1'b1);
        RREADY = 1'b0;
        ar(4'hC, 16'h0000, 8'd0);
        rbeat(4'hC, 32'h5A5A5A5A, 2'b00, 1'b1);
        RREADY = 1'b0;

        // early WLAST, with a read running during W_DATA
        aw(4'h4, 16'h0080, 8'd3);
        chk("wready_in_data", WREADY, 1);
        ar(4'hD, 16'h0010, 8'd0);
        rbeat(4'hD, 32'hDEADBEEF, 2'b00, 1'b1);
        RREADY = 1'b0;
        chk("wready_after_read", WREADY, 1);
        wbeat(32'hC0, 4'hF, 1'b0);
        wbeat(32'hC1, 4'hF, 1'b1);
        wbeat(32'hC2, 4'hF, 1'b0);
        wbeat(32'hC3, 4'hF, 1'b0);
        chk("wready_after_4", WREADY, 0);
        bresp(4'h4, 2'b10);
        ar(4'hE, 16'h0080, 8'd3);
        rbeat(4'hE, 32'hC0, 2'b00, 1'b0);
        rbeat(4'hE, 32'hC1, 2'b00, 1'b0);
        rbeat(4'hE, 32'hC2, 2'b00, 1'b0);
        rbeat(4'hE, 32'hC3, 2'b00, 1'b1);
        RREADY = 1'b0;

        // reset in the middle of a read burst
        ar(4'h1, 16'h0040, 8'd7);
        rbeat(4'h1, 32'h100, 2'b00, 1'b0);
        rbeat(4'h1, 32'h101, 2'b00, 1'b0);
        RREADY = 1'b0;
        ARESETn = 1'b0;
        #1;
        chk("mid_rst_rvalid", RVALID, 0);
        chk("mid_rst_arready", ARREADY, 0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        @(negedge ACLK);
        chk("post_rst_arready", ARREADY, 1);
        chk("post_rst_rvalid", RVALID, 0);
        ar(4'h2, 16'h0010, 8'd0);
        rbeat(4'h2, 32'hDEADBEEF, 2'b00, 1'b1);
        RREADY = 1'b0;
        ar(4'h3, 16'h0040, 8'd0);
        rbeat(4'h3, 32'h100, 2'b00, 1'b1);
        RREADY = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
